// File: rtl/mem_stage_sram_ctrl.sv
// ============================================================================
// Module   : mem_stage_sram_ctrl
// Brief    : MEM-stage data-memory controller driving a multi-cycle synchronous
//            SRAM; stalls the pipeline while an access is in flight.
// Options  : ALIGN_CHECK_EN - flag and suppress word-misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_sram_ctrl #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        MEM_CMD_MEM,
    input  logic [31:0]       ALU_res_MEM,
    input  logic [31:0]       src2_val_MEM,
    input  logic              WB_EN_MEM,
    input  logic [4:0]        Dst_MEM,
    output logic              freeze,
    output logic [31:0]       MEM_result_out,
    output logic [31:0]       ALU_res_out,
    output logic              WB_EN_out,
    output logic [4:0]        Dst_out,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    input  logic [31:0]       sram_rdata,
    output logic              misalign_err
);

    localparam int          c_CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [31:0] c_BASE  = 32'(ADDR_BASE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_start;
    logic               w_req;
    logic               w_misalign;
    logic               w_cnt_zero;
    logic [31:0]        w_offset;
    logic [31:0]        w_word;
    logic               w_unused_addr;

    assign ALU_res_out = ALU_res_MEM;
    assign WB_EN_out   = WB_EN_MEM;
    assign Dst_out     = Dst_MEM;

    // Wrap-around subtraction: addresses below the base map to the top of SRAM.
    assign w_offset      = ALU_res_MEM - c_BASE;
    assign w_word        = w_offset >> 2;
    assign w_unused_addr = &{1'b0, w_word};
    assign w_cnt_zero    = (r_cnt == '0);

`ifdef ALIGN_CHECK_EN
    logic r_misalign;

    assign w_misalign   = (ALU_res_MEM[1:0] != 2'b00);
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (r_state == IDLE && MEM_CMD_MEM != 2'b00 && w_misalign) begin
            r_misalign <= 1'b1;
        end
    end
`else
    assign w_misalign   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign w_req = (MEM_CMD_MEM != 2'b00) && !w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        freeze  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_start = 1'b1;
                    freeze  = 1'b1;
                    w_next  = ACCESS;
                end
            end
            ACCESS: begin
                freeze = 1'b1;
                if (w_cnt_zero) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // Release the stall the instant reset hits, whatever the inputs say.
        if (rst) begin
            freeze = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            sram_we        <= 1'b0;
            sram_oe        <= 1'b0;
            MEM_result_out <= '0;
        end else if (w_start) begin
            r_cnt      <= c_CNT_W'(WAIT_CYCLES - 1);
            sram_addr  <= w_word[ADDR_W-1:0];
            sram_wdata <= src2_val_MEM;
            sram_we    <= MEM_CMD_MEM[1];
            sram_oe    <= ~MEM_CMD_MEM[1];
        end else if (r_state == ACCESS) begin
            if (w_cnt_zero) begin
                // sram_oe doubles as the "this access is a load" marker.
                if (sram_oe) begin
                    MEM_result_out <= sram_rdata;
                end
                sram_we <= 1'b0;
                sram_oe <= 1'b0;
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_sram_ctrl
// Brief    : Directed self-checking bench for mem_stage_sram_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  MEM_CMD_MEM = 2'b00;
    logic [31:0] ALU_res_MEM = '0;
    logic [31:0] src2_val_MEM = '0;
    logic        WB_EN_MEM = 1'b0;
    logic [4:0]  Dst_MEM = '0;
    logic [31:0] sram_rdata = '0;
    logic        freeze;
    logic [31:0] MEM_result_out;
    logic [31:0] ALU_res_out;
    logic        WB_EN_out;
    logic [4:0]  Dst_out;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic        sram_oe;
    logic        misalign_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc, n_we, n_oe;
    logic [15:0] addr_seen;

    mem_stage_sram_ctrl #(
        .WAIT_CYCLES(5),
        .ADDR_BASE  (1024),
        .ADDR_W     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_CMD_MEM   (MEM_CMD_MEM),
        .ALU_res_MEM   (ALU_res_MEM),
        .src2_val_MEM  (src2_val_MEM),
        .WB_EN_MEM     (WB_EN_MEM),
        .Dst_MEM       (Dst_MEM),
        .freeze        (freeze),
        .MEM_result_out(MEM_result_out),
        .ALU_res_out   (ALU_res_out),
        .WB_EN_out     (WB_EN_out),
        .Dst_out       (Dst_out),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_we       (sram_we),
        .sram_oe       (sram_oe),
        .sram_rdata    (sram_rdata),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] cmd, input logic [31:0] alu, input logic [31:0] src2);
        MEM_CMD_MEM  = cmd;
        ALU_res_MEM  = alu;
        src2_val_MEM = src2;
        #1;
    endtask

    // From cycle 0 (request visible) advance until freeze drops; ends in DONE.
    task automatic run_op(output int c, output int nw, output int no, output logic [15:0] a);
        c  = 1;
        nw = 0;
        no = 0;
        a  = 16'hxxxx;
        while (freeze && c < 20) begin
            tick();
            c++;
            if (sram_we) nw++;
            if (sram_oe) no++;
            if (sram_we || sram_oe) a = sram_addr;
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_freeze", freeze, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_oe", sram_oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_result", MEM_result_out, 0);
        chk("rst_misalign", misalign_err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Load at 1024+8 -> word 2, followed directly by a store.
        sram_rdata = 32'hDEADBEEF;
        set_in(2'b01, 32'd1032, 32'h0);
        chk("ld_c0_freeze", freeze, 1);
        chk("ld_c0_oe", sram_oe, 0);
        run_op(cyc, n_we, n_oe, addr_seen);
        chk("ld_cycles", cyc, 7);
        chk("ld_oe_cycles", n_oe, 5);
        chk("ld_we_cycles", n_we, 0);
        chk("ld_addr", addr_seen, 16'd2);
        chk("ld_done_result", MEM_result_out, 32'hDEADBEEF);
        chk("ld_done_oe", sram_oe, 0);

        set_in(2'b10, 32'd1040, 32'h12345678);
        chk("done_freeze_low", freeze, 0);
        chk("done_no_strobe", sram_we | sram_oe, 0);
        tick();
        chk("st_c0_freeze", freeze, 1);
        chk("st_c0_we", sram_we, 0);
        run_op(cyc, n_we, n_oe, addr_seen);
        chk("st_cycles", cyc, 7);
        chk("st_we_cycles", n_we, 5);
        chk("st_oe_cycles", n_oe, 0);
        chk("st_addr", addr_seen, 16'd4);
        chk("st_wdata", sram_wdata, 32'h12345678);
        chk("st_result_kept", MEM_result_out, 32'hDEADBEEF);
        chk("st_done_we", sram_we, 0);

        // Non-memory op: passthrough and no stall.
        set_in(2'b00, 32'h55, 32'h0);
        WB_EN_MEM = 1'b1;
        Dst_MEM   = 5'd7;
        tick();
        chk("nm_freeze", freeze, 0);
        chk("nm_strobes", {sram_we, sram_oe}, 0);
        chk("nm_alu", ALU_res_out, 32'h55);
        chk("nm_wben", WB_EN_out, 1);
        chk("nm_dst", Dst_out, 7);
        tick();
        chk("nm_freeze_next", freeze, 0);
        chk("nm_result_kept", MEM_result_out, 32'hDEADBEEF);

        // Command 11 behaves as a store.
        sram_rdata = 32'h0BADF00D;
        set_in(2'b11, 32'd1028, 32'hA5A5A5A5);
        run_op(cyc, n_we, n_oe, addr_seen);
        chk("c11_cycles", cyc, 7);
        chk("c11_we_cycles", n_we, 5);
        chk("c11_oe_cycles", n_oe, 0);
        chk("c11_addr", addr_seen, 16'd1);
        chk("c11_result_kept", MEM_result_out, 32'hDEADBEEF);

        // Address below the base wraps: (1020-1024)>>2 truncated = 0xFFFF.
        set_in(2'b00, 32'h0, 32'h0);
        tick();
        sram_rdata = 32'h01020304;
        set_in(2'b01, 32'd1020, 32'h0);
        run_op(cyc, n_we, n_oe, addr_seen);
        chk("wrap_addr", addr_seen, 16'hFFFF);
        chk("wrap_result", MEM_result_out, 32'h01020304);

        // Reset during the 3rd ACCESS cycle of a store.
        set_in(2'b00, 32'h0, 32'h0);
        tick();
        set_in(2'b10, 32'd1044, 32'h0000AAAA);
        tick();
        tick();
        tick();
        chk("pre_rst_we", sram_we, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", sram_we, 0);
        chk("mid_rst_freeze", freeze, 0);
        chk("mid_rst_result", MEM_result_out, 0);
        set_in(2'b00, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle_freeze", freeze, 0);
        sram_rdata = 32'hCAFEF00D;
        set_in(2'b01, 32'd1036, 32'h0);
        chk("post_rst_c0_freeze", freeze, 1);
        run_op(cyc, n_we, n_oe, addr_seen);
        chk("post_rst_cycles", cyc, 7);
        chk("post_rst_oe_cycles", n_oe, 5);
        chk("post_rst_addr", addr_seen, 16'd3);
        chk("post_rst_result", MEM_result_out, 32'hCAFEF00D);

        // Misaligned load at 1026.
        set_in(2'b00, 32'h0, 32'h0);
        tick();
        sram_rdata = 32'h77778888;
        set_in(2'b01, 32'd1026, 32'h0);
`ifdef ALIGN_CHECK_EN
        chk("mis_c0_freeze", freeze, 0);
        tick();
        chk("mis_flag", misalign_err, 1);
        chk("mis_no_oe", sram_oe, 0);
        chk("mis_freeze", freeze, 0);
        chk("mis_result_kept", MEM_result_out, 32'hCAFEF00D);
        set_in(2'b01, 32'd1024, 32'h0);
        run_op(cyc, n_we, n_oe, addr_seen);
        chk("mis_next_cycles", cyc, 7);
        chk("mis_next_result", MEM_result_out, 32'h77778888);
        chk("mis_flag_sticky", misalign_err, 1);
`else
        chk("mis_c0_freeze", freeze, 1);
        run_op(cyc, n_we, n_oe, addr_seen);
        chk("mis_cycles", cyc, 7);
        chk("mis_addr", addr_seen, 16'd0);
        chk("mis_result", MEM_result_out, 32'h77778888);
        chk("mis_flag_tied", misalign_err, 0);
`endif
        set_in(2'b00, 32'h0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
